gshare_bht: RTL

Parametrised gshare branch-history table, the successor to the fixed 256×2-bit BHT. It holds 2^IDX_W saturating counters of CNT_W bits, indexed by the branch PC index XORed with a global history register (GHR). The GHR is updated speculatively on each prediction and repaired on mispredict. Reset clears the table with a one-entry-per-cycle sweep, so the table can map to single-port-write RAM. The block sits between IF (lookup) and the commit/branch-resolve stage (update).

---
 rtl/gshare_bht_if.sv | 27 ++
 rtl/gshare_bht.sv | 71 +++++++
 2 files changed

// File: rtl/gshare_bht_if.sv
// gshare_bht_if: lookup/update/status bundle between IF, the commit stage and the gshare predictor.
interface gshare_bht_if #(
   parameter int IDX_W      = 8,
   parameter int HIST_W     = 8,
   parameter int CNT_W_MISS = 32
);
   logic                  rdy;
   logic                  pred_valid;
   logic [IDX_W-1:0]      pred_idx;
   logic                  pred_taken;
   logic [HIST_W-1:0]     pred_hist;
   logic                  upd_valid;
   logic [IDX_W-1:0]      upd_idx;
   logic [HIST_W-1:0]     upd_hist;
   logic                  upd_taken;
   logic                  upd_mispredict;
   logic                  busy;
   logic [CNT_W_MISS-1:0] miss_cnt;
   modport master (
      output rdy, pred_valid, pred_idx, upd_valid, upd_idx, upd_hist, upd_taken, upd_mispredict,
      input  pred_taken, pred_hist, busy, miss_cnt
   );
   modport slave (
      input  rdy, pred_valid, pred_idx, upd_valid, upd_idx, upd_hist, upd_taken, upd_mispredict,
      output pred_taken, pred_hist, busy, miss_cnt
   );
endinterface

// File: rtl/gshare_bht.sv
// gshare_bht: gshare predictor with saturating counters, speculative GHR with mispredict repair,
// and a one-entry-per-cycle init sweep so the table fits a single-write-port RAM.
module gshare_bht #(
   parameter int IDX_W      = 8,
   parameter int HIST_W     = 8,
   parameter int CNT_W      = 2,
   parameter int CNT_W_MISS = 32
) (
   input logic         clk,
   input logic         rst,
   gshare_bht_if.slave bus
);
   localparam logic [CNT_W-1:0] INIT_VAL = CNT_W'(2 ** (CNT_W - 1) - 1);
   typedef enum logic {INIT, RUN} state_t;
   state_t                r_state;
   logic [IDX_W-1:0]      r_ptr;
   logic [HIST_W-1:0]     r_ghr;
   logic [CNT_W_MISS-1:0] r_miss;
   logic [CNT_W-1:0]      r_tab [2 ** IDX_W];
   logic                  w_run;
   logic                  w_miss;
   logic [IDX_W-1:0]      w_pidx;
   logic [IDX_W-1:0]      w_uidx;
   logic [CNT_W-1:0]      w_pcnt;
   logic [CNT_W-1:0]      w_ucnt;
   logic [CNT_W-1:0]      w_unxt;
   logic [HIST_W-1:0]     w_rep;
   logic [HIST_W-1:0]     w_shift;
   always_comb begin
      w_run   = r_state == RUN;
      w_miss  = bus.upd_valid & bus.upd_mispredict;
      w_pidx  = bus.pred_idx ^ IDX_W'(r_ghr);
      w_uidx  = bus.upd_idx ^ IDX_W'(bus.upd_hist);
      w_pcnt  = r_tab[w_pidx];
      w_ucnt  = r_tab[w_uidx];
      w_unxt  = bus.upd_taken ? ((&w_ucnt) ? w_ucnt : w_ucnt + 1'b1)
                              : ((|w_ucnt) ? w_ucnt - 1'b1 : w_ucnt);
      // truncating the concatenation drops the oldest bit and also covers HIST_W == 1
      w_rep   = HIST_W'({bus.upd_hist, bus.upd_taken});
      w_shift = HIST_W'({r_ghr, bus.pred_taken});
   end
   assign bus.pred_taken = w_run & w_pcnt[CNT_W-1];
   assign bus.pred_hist  = w_run ? r_ghr : '0;
   assign bus.busy       = ~w_run;
   assign bus.miss_cnt   = r_miss;
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= INIT;
         r_ptr   <= '0;
         r_ghr   <= '0;
         r_miss  <= '0;
      end else if (bus.rdy) begin
         if (!w_run) begin
            r_ptr <= r_ptr + 1'b1;
            if (&r_ptr) r_state <= RUN;
         end else if (w_miss) begin
            r_ghr  <= w_rep;
            r_miss <= r_miss + 1'b1;
         end else if (bus.pred_valid) begin
            r_ghr <= w_shift;
         end
      end
   end
   // single write port: sweep writes during INIT, resolved updates during RUN
   always_ff @(posedge clk) begin
      if (!rst && bus.rdy) begin
         if (!w_run) r_tab[r_ptr] <= INIT_VAL;
         else if (bus.upd_valid) r_tab[w_uidx] <= w_unxt;
      end
   end
endmodule
